// File: rtl/playback.sv
// Replay engine for recorded switch segments. Each segment has a level and a
// duration in 10 ms ticks. The replay timing is derived from Div_CLK through
// a prescaler of TICK_DIV cycles.
module playback #(
  parameter int TICK_DIV = 102
) (
  input  logic       Div_CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] num_seg,
  output logic [2:0] rd_index,
  input  logic       rd_level,
  input  logic [6:0] rd_dur,
  output logic       play_switch,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] PRE_MAX = 8'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

  state_t     state;
  logic [7:0] prescaler;
  logic [6:0] remaining;
  logic [3:0] num_q;      // segment count captured at start, clipped to 8
  logic       start_q;    // start accepted in IDLE, acted on one edge later
  logic [3:0] num_clip;
  logic       last_seg;

  assign num_clip = (num_seg > 4'd8) ? 4'd8 : num_seg;
  assign last_seg = ({1'b0, rd_index} == (num_q - 4'd1));

  // Replay state machine with all outputs registered; abort overrides everything.
  always_ff @(posedge Div_CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      play_switch <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_index    <= 3'd0;
      prescaler   <= 8'd0;
      remaining   <= 7'd0;
      num_q       <= 4'd0;
      start_q     <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      play_switch <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_index    <= 3'd0;
      prescaler   <= 8'd0;
      remaining   <= 7'd0;
      start_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          play_switch <= 1'b0;
          done        <= 1'b0;
          rd_index    <= 3'd0;
          prescaler   <= 8'd0;
          if (start_q) begin
            // A second start during the launch edge is not a new request.
            start_q <= 1'b0;
            if (num_q == 4'd0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= LOAD;
              busy  <= 1'b1;
            end
          end else begin
            busy    <= 1'b0;
            start_q <= start;
            if (start) num_q <= num_clip;
          end
        end

        LOAD: begin
          play_switch <= rd_level;
          remaining   <= rd_dur;
          prescaler   <= 8'd0;
          if (rd_dur == 7'd0) begin
            // Zero-length segment: skip straight to the next one.
            if (last_seg) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              rd_index <= rd_index + 3'd1;
            end
          end else begin
            state <= PLAY;
          end
        end

        PLAY: begin
          if (prescaler == PRE_MAX) begin
            prescaler <= 8'd0;
            if (remaining <= 7'd1) begin
              remaining <= 7'd0;
              if (last_seg) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                rd_index <= rd_index + 3'd1;
                state    <= LOAD;
              end
            end else begin
              remaining <= remaining - 7'd1;
            end
          end else begin
            prescaler <= prescaler + 8'd1;
          end
        end

        DONE: begin
          done        <= 1'b0;
          busy        <= 1'b0;
          play_switch <= 1'b0;
          rd_index    <= 3'd0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_playback.sv
// Directed bench for playback with TICK_DIV=4 and a small segment memory.
module tb_playback;

  logic       Div_CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] num_seg = 4'd0;
  logic [2:0] rd_index;
  logic       rd_level;
  logic [6:0] rd_dur;
  logic       play_switch;
  logic       busy;
  logic       done;

  logic       lvl_mem [8];
  logic [6:0] dur_mem [8];

  assign rd_level = lvl_mem[rd_index];
  assign rd_dur   = dur_mem[rd_index];

  playback #(.TICK_DIV(4)) dut (
    .Div_CLK    (Div_CLK),
    .RST        (RST),
    .start      (start),
    .abort      (abort),
    .num_seg    (num_seg),
    .rd_index   (rd_index),
    .rd_level   (rd_level),
    .rd_dur     (rd_dur),
    .play_switch(play_switch),
    .busy       (busy),
    .done       (done)
  );

  always #5 Div_CLK = ~Div_CLK;

  typedef struct {
    int         num;
    logic [7:0] lvl;
    int         d [8];
    int         e_done;
    int         e_hi;
    int         e_busy;
    int         e_max;
    int         e_first;
  } vec_t;

  vec_t vecs [6];

  int checks = 0;
  int failures = 0;

  int m_done_cyc, m_done_cnt, m_hi, m_busy, m_max, m_first;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_mem(input vec_t v);
    for (int i = 0; i < 8; i++) begin
      lvl_mem[i] = v.lvl[i];
      dur_mem[i] = 7'(v.d[i]);
    end
  endtask

  // Called just after a negedge. Start is sampled at edge 0; cycle k is the
  // interval after edge k and is observed at the following negedge. A second
  // start is injected so that it is sampled at edge extra+1 (-1 = none).
  task automatic play(input int num, input int extra);
    m_done_cyc = -1; m_done_cnt = 0; m_hi = 0; m_busy = 0; m_max = 0; m_first = -1;
    num_seg = 4'(num);
    start = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge Div_CLK);
      start = (k == extra);
      if (done) begin
        m_done_cnt++;
        if (m_done_cyc < 0) m_done_cyc = k;
      end
      if (play_switch) begin
        m_hi++;
        if (m_first < 0) m_first = k;
      end
      if (busy) m_busy++;
      if (int'(rd_index) > m_max) m_max = int'(rd_index);
    end
    start = 1'b0;
  endtask

  initial begin
    int cnt;
    vecs[0] = '{2,  8'b0000_0001, '{3, 2, 0, 0, 0, 0, 0, 0}, 23, 13, 22, 1, 2};
    vecs[1] = '{0,  8'b0000_0000, '{0, 0, 0, 0, 0, 0, 0, 0},  1,  0,  0, 0, -1};
    vecs[2] = '{3,  8'b0000_0101, '{2, 0, 1, 0, 0, 0, 0, 0}, 16, 14, 15, 2, 2};
    vecs[3] = '{12, 8'b1111_1111, '{1, 1, 1, 1, 1, 1, 1, 1}, 41, 40, 40, 7, 2};
    vecs[4] = '{1,  8'b0000_0001, '{0, 0, 0, 0, 0, 0, 0, 0},  2,  1,  1, 0, 2};
    vecs[5] = '{8,  8'b1010_1010, '{1, 1, 1, 1, 1, 1, 1, 1}, 41, 20, 40, 7, 7};
    load_mem(vecs[0]);

    // Reset values
    repeat (2) @(negedge Div_CLK);
    chk("rst_play_switch", int'(play_switch), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_index", int'(rd_index), 0);
    RST = 1'b0;
    @(negedge Div_CLK);

    // Table-driven replays
    for (int v = 0; v < 6; v++) begin
      load_mem(vecs[v]);
      play(vecs[v].num, -1);
      chk($sformatf("v%0d_done_cycle", v), m_done_cyc, vecs[v].e_done);
      chk($sformatf("v%0d_done_pulses", v), m_done_cnt, 1);
      chk($sformatf("v%0d_high_cycles", v), m_hi, vecs[v].e_hi);
      chk($sformatf("v%0d_busy_cycles", v), m_busy, vecs[v].e_busy);
      chk($sformatf("v%0d_max_index", v), m_max, vecs[v].e_max);
      chk($sformatf("v%0d_first_high", v), m_first, vecs[v].e_first);
    end

    // Abort during PLAY of seg0, then a normal replay
    load_mem(vecs[0]);
    num_seg = 4'd2;
    start = 1'b1;
    @(negedge Div_CLK);
    start = 1'b0;
    repeat (5) @(negedge Div_CLK);
    chk("pre_abort_busy", int'(busy), 1);
    chk("pre_abort_switch", int'(play_switch), 1);
    abort = 1'b1;
    @(negedge Div_CLK);
    abort = 1'b0;
    chk("abort_switch", int'(play_switch), 0);
    chk("abort_busy", int'(busy), 0);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (done || busy) cnt++;
      @(negedge Div_CLK);
    end
    chk("abort_no_done", cnt, 0);
    play(2, -1);
    chk("after_abort_done_cycle", m_done_cyc, 23);
    chk("after_abort_high", m_hi, 13);

    // Abort and start together in IDLE: nothing starts
    start = 1'b1;
    abort = 1'b1;
    @(negedge Div_CLK);
    start = 1'b0;
    abort = 1'b0;
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      if (done || busy || play_switch) cnt++;
      @(negedge Div_CLK);
    end
    chk("abort_start_idle", cnt, 0);

    // RST mid-PLAY, restart 3 cycles later, extra start while busy ignored
    start = 1'b1;
    @(negedge Div_CLK);
    start = 1'b0;
    repeat (6) @(negedge Div_CLK);
    RST = 1'b1;
    #1;
    chk("midrst_switch", int'(play_switch), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_index", int'(rd_index), 0);
    @(negedge Div_CLK);
    chk("midrst_done", int'(done), 0);
    RST = 1'b0;
    repeat (3) @(negedge Div_CLK);
    play(2, 5);
    chk("rst_restart_done_cycle", m_done_cyc, 23);
    chk("rst_restart_done_pulses", m_done_cnt, 1);
    chk("rst_restart_high", m_hi, 13);
    chk("rst_restart_busy", m_busy, 22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
